// File: rtl/elevator_motion_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | elevator_motion_if : command/status bundle between controller and car    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface elevator_motion_if #(
    parameter int F_BITS = 2
);
    logic [1:0]        command;
    logic              hold;
    logic [F_BITS-1:0] cur_floor;
    logic              door_open;
    logic              moving_up;
    logic              moving_down;
    logic              arrive_pulse;
    logic              serve_completing;
    logic              served_pulse;
    logic              cmd_err;

    modport master (
        output command,
        output hold,
        input  cur_floor,
        input  door_open,
        input  moving_up,
        input  moving_down,
        input  arrive_pulse,
        input  serve_completing,
        input  served_pulse,
        input  cmd_err
    );

    modport slave (
        input  command,
        input  hold,
        output cur_floor,
        output door_open,
        output moving_up,
        output moving_down,
        output arrive_pulse,
        output serve_completing,
        output served_pulse,
        output cmd_err
    );
endinterface
`default_nettype wire

// File: rtl/elevator_motion.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | elevator_motion : car travel and door dwell timing behind the controller |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module elevator_motion #(
    parameter int N             = 4,
    parameter int F_BITS        = $clog2(N),
    parameter int TRAVEL_CYCLES = 8,
    parameter int SERVE_CYCLES  = 5,
    parameter int RESET_FLOOR   = 0
) (
    input  wire logic         clk,
    input  wire logic         rst,
    elevator_motion_if.slave  bus
);

    localparam int C_MAX  = (TRAVEL_CYCLES > SERVE_CYCLES) ? TRAVEL_CYCLES : SERVE_CYCLES;
    localparam int C_BITS = $clog2(C_MAX + 1);

    localparam logic [C_BITS-1:0] c_travel_load = C_BITS'(TRAVEL_CYCLES - 1);
    localparam logic [C_BITS-1:0] c_serve_load  = C_BITS'(SERVE_CYCLES - 1);
    localparam logic [C_BITS-1:0] c_cnt_zero    = '0;
    localparam logic [C_BITS-1:0] c_cnt_one     = C_BITS'(1);
    localparam logic [C_BITS-1:0] c_cnt_two     = C_BITS'(2);
    localparam logic [F_BITS-1:0] c_top_floor   = F_BITS'(N - 1);
    localparam logic [F_BITS-1:0] c_bot_floor   = '0;
    localparam logic [F_BITS-1:0] c_reset_floor = F_BITS'(RESET_FLOOR);
    localparam logic [F_BITS-1:0] c_floor_step  = F_BITS'(1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_MOVE_UP = 2'd1,
        S_MOVE_DN = 2'd2,
        S_SERVE   = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [C_BITS-1:0] r_cnt;
    logic [C_BITS-1:0] w_cnt_nxt;
    logic [F_BITS-1:0] r_floor;
    logic [F_BITS-1:0] w_floor_nxt;
    logic              r_arrive;
    logic              w_arrive_nxt;
    logic              r_err;
    logic              w_err_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= c_cnt_zero;
            r_floor  <= c_reset_floor;
            r_arrive <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_floor  <= w_floor_nxt;
            r_arrive <= w_arrive_nxt;
            r_err    <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_floor_nxt  = r_floor;
        w_arrive_nxt = 1'b0;
        w_err_nxt    = 1'b0;
        case (r_state)
            S_IDLE: begin
                case (bus.command)
                    2'b11: begin
                        w_state_nxt = S_SERVE;
                        w_cnt_nxt   = c_serve_load;
                    end
                    2'b01: begin
                        if (r_floor < c_top_floor) begin
                            w_state_nxt = S_MOVE_UP;
                            w_cnt_nxt   = c_travel_load;
                        end else begin
                            w_err_nxt = 1'b1;
                        end
                    end
                    2'b10: begin
                        if (r_floor > c_bot_floor) begin
                            w_state_nxt = S_MOVE_DN;
                            w_cnt_nxt   = c_travel_load;
                        end else begin
                            w_err_nxt = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
            S_MOVE_UP, S_MOVE_DN: begin
                if (r_cnt == c_cnt_zero) begin
                    w_floor_nxt  = (r_state == S_MOVE_UP) ? (r_floor + c_floor_step)
                                                          : (r_floor - c_floor_step);
                    w_state_nxt  = S_IDLE;
                    w_arrive_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - c_cnt_one;
                end
            end
            S_SERVE: begin
                // Once cnt<=1 the controller has committed its clears, so hold is too late.
                if (bus.hold && (r_cnt >= c_cnt_two)) begin
                    w_cnt_nxt = c_serve_load;
                end else if (r_cnt == c_cnt_zero) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - c_cnt_one;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = c_cnt_zero;
            end
        endcase
    end

    // Outputs come from registers only, breaking any loop through the controller.
    assign bus.cur_floor        = r_floor;
    assign bus.door_open        = (r_state == S_SERVE);
    assign bus.moving_up        = (r_state == S_MOVE_UP);
    assign bus.moving_down      = (r_state == S_MOVE_DN);
    assign bus.arrive_pulse     = r_arrive;
    assign bus.serve_completing = (r_state == S_SERVE) && (r_cnt == c_cnt_one);
    assign bus.served_pulse     = (r_state == S_SERVE) && (r_cnt == c_cnt_zero);
    assign bus.cmd_err          = r_err;

endmodule
`default_nettype wire

// File: tb/tb_elevator_motion.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_elevator_motion : directed and random checks against a timing model   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_elevator_motion;

    localparam int N      = 4;
    localparam int F_BITS = 2;
    localparam int T      = 8;
    localparam int S      = 5;
    localparam int RF     = 0;

    localparam int M_IDLE = 0;
    localparam int M_UP   = 1;
    localparam int M_DN   = 2;
    localparam int M_SRV  = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    elevator_motion_if #(.F_BITS(F_BITS)) bus();

    elevator_motion #(
        .N(N), .F_BITS(F_BITS), .TRAVEL_CYCLES(T), .SERVE_CYCLES(S), .RESET_FLOOR(RF)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int errors = 0;
    int checks = 0;

    // Model: m_left counts the cycles of the current operation still to be shown,
    // including the present one.
    int m_floor, m_mode, m_left;
    bit m_arr, m_err;

    int n_up, n_dn, n_door, n_srv, n_cmp, n_arr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_floor = RF; m_mode = M_IDLE; m_left = 0; m_arr = 0; m_err = 0;
    endtask

    task automatic clr();
        n_up = 0; n_dn = 0; n_door = 0; n_srv = 0; n_cmp = 0; n_arr = 0;
    endtask

    task automatic check_all();
        chk("cur_floor",        32'(bus.cur_floor),        32'(m_floor));
        chk("door_open",        32'(bus.door_open),        32'(m_mode == M_SRV));
        chk("moving_up",        32'(bus.moving_up),        32'(m_mode == M_UP));
        chk("moving_down",      32'(bus.moving_down),      32'(m_mode == M_DN));
        chk("arrive_pulse",     32'(bus.arrive_pulse),     32'(m_arr));
        chk("serve_completing", 32'(bus.serve_completing), 32'(m_mode == M_SRV && m_left == 2));
        chk("served_pulse",     32'(bus.served_pulse),     32'(m_mode == M_SRV && m_left == 1));
        chk("cmd_err",          32'(bus.cmd_err),          32'(m_err));
        chk("served_vs_completing", 32'(bus.served_pulse & bus.serve_completing), 32'd0);
        chk("served_vs_arrive",     32'(bus.served_pulse & bus.arrive_pulse),     32'd0);
    endtask

    task automatic cycle(input logic [1:0] cmd, input logic hld);
        bus.command = cmd;
        bus.hold    = hld;
        @(posedge clk);
        m_arr = 0;
        m_err = 0;
        case (m_mode)
            M_IDLE: begin
                if (cmd == 2'd3) begin
                    m_mode = M_SRV; m_left = S;
                end else if (cmd == 2'd1) begin
                    if (m_floor < N - 1) begin m_mode = M_UP; m_left = T; end
                    else m_err = 1;
                end else if (cmd == 2'd2) begin
                    if (m_floor > 0) begin m_mode = M_DN; m_left = T; end
                    else m_err = 1;
                end
            end
            M_UP, M_DN: begin
                m_left--;
                if (m_left == 0) begin
                    m_floor = (m_mode == M_UP) ? m_floor + 1 : m_floor - 1;
                    m_mode  = M_IDLE;
                    m_arr   = 1;
                end
            end
            default: begin
                if (hld && m_left >= 3) m_left = S;
                else m_left--;
                if (m_left == 0) m_mode = M_IDLE;
            end
        endcase
        #1;
        check_all();
        n_up   += int'(bus.moving_up);
        n_dn   += int'(bus.moving_down);
        n_door += int'(bus.door_open);
        n_srv  += int'(bus.served_pulse);
        n_cmp  += int'(bus.serve_completing);
        n_arr  += int'(bus.arrive_pulse);
    endtask

    task automatic async_reset();
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rst = 1'b0;
        bus.command = 2'd0;
        bus.hold    = 1'b0;
    endtask

    initial begin
        bus.command = 2'd0;
        bus.hold    = 1'b0;
        model_reset();
        #2;
        check_all();
        @(negedge clk);
        rst = 1'b0;

        // Move 0 -> 1
        clr();
        cycle(2'd1, 1'b0);
        repeat (9) cycle(2'd0, 1'b0);
        chk("up_cycles", 32'(n_up), 32'(T));
        chk("arrive_count", 32'(n_arr), 32'd1);
        chk("floor_after_up", 32'(bus.cur_floor), 32'd1);

        // Move 1 -> 2 with commands toggling during travel
        clr();
        cycle(2'd1, 1'b0);
        for (int i = 0; i < T; i++) cycle((i % 2 == 0) ? 2'b10 : 2'b11, 1'b0);
        cycle(2'd0, 1'b0);
        chk("noisy_up_cycles", 32'(n_up), 32'(T));
        chk("noisy_floor", 32'(bus.cur_floor), 32'd2);
        chk("noisy_no_down", 32'(n_dn), 32'd0);

        // Serve at floor 2 with 11 held through the serve
        clr();
        repeat (S + 1) cycle(2'd3, 1'b0);
        repeat (2) cycle(2'd0, 1'b0);
        chk("serve_door_cycles", 32'(n_door), 32'(S));
        chk("serve_served_count", 32'(n_srv), 32'd1);
        chk("serve_completing_count", 32'(n_cmp), 32'd1);

        // Hold while cnt=3 stretches the door to 7 cycles
        clr();
        cycle(2'd3, 1'b0);
        cycle(2'd0, 1'b0);
        cycle(2'd0, 1'b1);
        repeat (6) cycle(2'd0, 1'b0);
        chk("hold_door_cycles", 32'(n_door), 32'd7);
        chk("hold_served_count", 32'(n_srv), 32'd1);

        // Hold while cnt=1 is ignored
        clr();
        cycle(2'd3, 1'b0);
        repeat (3) cycle(2'd0, 1'b0);
        cycle(2'd0, 1'b1);
        chk("late_hold_served", 32'(bus.served_pulse), 32'd1);
        cycle(2'd0, 1'b0);
        chk("late_hold_door_cycles", 32'(n_door), 32'(S));

        // Climb to the top floor, then reject another up
        cycle(2'd1, 1'b0);
        repeat (T) cycle(2'd0, 1'b0);
        chk("floor_top", 32'(bus.cur_floor), 32'(N - 1));
        clr();
        cycle(2'd1, 1'b0);
        chk("cmd_err_top", 32'(bus.cmd_err), 32'd1);
        cycle(2'd0, 1'b0);
        chk("cmd_err_top_once", 32'(bus.cmd_err), 32'd0);
        chk("top_no_motion", 32'(n_up), 32'd0);

        // Reject down at floor 0
        async_reset();
        cycle(2'd2, 1'b0);
        chk("cmd_err_bottom", 32'(bus.cmd_err), 32'd1);
        chk("bottom_floor", 32'(bus.cur_floor), 32'd0);
        cycle(2'd0, 1'b0);

        // Reset mid-move at cnt=3
        cycle(2'd1, 1'b0);
        repeat (4) cycle(2'd0, 1'b0);
        async_reset();
        clr();
        repeat (3) cycle(2'd0, 1'b0);
        chk("reset_move_no_arrive", 32'(n_arr), 32'd0);

        // Reset mid-serve at cnt=1
        cycle(2'd3, 1'b0);
        repeat (3) cycle(2'd0, 1'b0);
        async_reset();
        clr();
        repeat (3) cycle(2'd0, 1'b0);
        chk("reset_serve_no_served", 32'(n_srv), 32'd0);

        // Random traffic
        repeat (600) begin
            logic [1:0] rc;
            logic       rh;
            rc = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 3)) : 2'd0;
            rh = ($urandom_range(0, 3) == 0);
            cycle(rc, rh);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
